// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage pipelined floating-point multiplier with round-to-nearest-even and valid/ready flow control
// Ports: clk; rst (synchronous, active-high); in_valid/in_ready/in_a/in_b on the operand side;
//        out_valid/out_ready/out_p on the result side; out_flags {invalid, overflow, underflow, inexact}
//        exists only when FP_MUL_FLAGS_EN is defined.
module fp_mul_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] in_a,
   input  logic [EXP_W+MAN_W:0] in_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] out_p
`ifdef FP_MUL_FLAGS_EN
   ,
   output logic [3:0]           out_flags
`endif
);
   localparam int W = 1 + EXP_W + MAN_W;
   localparam int PW = 2 * MAN_W + 2;
   localparam int XW = EXP_W + 2;
   localparam logic [XW-1:0] BIAS = XW'(2 ** (EXP_W - 1) - 1);
   localparam logic [XW-1:0] XMAX = XW'(2 ** EXP_W - 1);
   localparam logic [EXP_W-1:0] EONE = '1;
   localparam logic [W-1:0] QNAN = {1'b0, EONE, 1'b1, {(MAN_W - 1){1'b0}}};
   logic adv;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb, mn;
   logic nan_a, nan_b, inf_a, inf_b, zro_a, zro_b;
   logic sgn, is_nan, is_inv, is_inf, is_zro;
   logic v1, s1, sp1, v2, s2, sp2;
   logic [XW-1:0] x1, x2, xn;
   logic [MAN_W:0] ma1, mb1, mr;
   logic [W-1:0] spv, spv1, spv2, res;
   logic [PW-1:0] p2;
   logic hi, g, st, rnd, ovf, unf;
`ifdef FP_MUL_FLAGS_EN
   logic inv1, inv2;
`endif
   assign adv = !out_valid || out_ready;
   assign in_ready = adv;
   assign {ea, fa} = in_a[W-2:0];
   assign {eb, fb} = in_b[W-2:0];
   assign nan_a = ea == EONE && fa != '0;
   assign nan_b = eb == EONE && fb != '0;
   assign inf_a = ea == EONE && fa == '0;
   assign inf_b = eb == EONE && fb == '0;
   assign zro_a = ea == '0;
   assign zro_b = eb == '0;
   assign sgn = in_a[W-1] ^ in_b[W-1];
   assign is_nan = nan_a || nan_b;
   assign is_inv = !is_nan && ((inf_a && zro_b) || (zro_a && inf_b));
   assign is_inf = !is_nan && !is_inv && (inf_a || inf_b);
   assign is_zro = !is_nan && !inf_a && !inf_b && (zro_a || zro_b);
   assign spv = (is_nan || is_inv) ? QNAN : is_inf ? {sgn, EONE, {MAN_W{1'b0}}} : {sgn, {(W - 1){1'b0}}};
   // product in [1,4): the top bit selects which window holds the stored mantissa
   assign hi = p2[PW-1];
   assign mn = hi ? p2[PW-2 -: MAN_W] : p2[PW-3 -: MAN_W];
   assign g = hi ? p2[MAN_W] : p2[MAN_W-1];
   assign st = hi ? |p2[MAN_W-1:0] : |p2[MAN_W-2:0];
   assign rnd = g && (st || mn[0]);
   // a rounding carry leaves the low MAN_W bits at zero, so only the exponent needs bumping
   assign mr = {1'b0, mn} + (MAN_W + 1)'(rnd);
   assign xn = x2 + XW'(hi) + XW'(mr[MAN_W]);
   assign ovf = !xn[XW-1] && xn >= XMAX;
   assign unf = xn[XW-1] || xn == '0;
   assign res = sp2 ? spv2 : ovf ? {s2, EONE, {MAN_W{1'b0}}} : unf ? {s2, {(W - 1){1'b0}}} : {s2, xn[EXP_W-1:0], mr[MAN_W-1:0]};
   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         out_valid <= 1'b0;
         out_p <= '0;
      end else if (adv) begin
         v1 <= in_valid;
         v2 <= v1;
         out_valid <= v2;
         if (v2) out_p <= res;
      end
   end
   always_ff @(posedge clk) begin
      if (adv) begin
         s1 <= sgn;
         x1 <= {2'b00, ea} + {2'b00, eb} - BIAS;
         ma1 <= {1'b1, fa};
         mb1 <= {1'b1, fb};
         sp1 <= is_nan || is_inv || is_inf || is_zro;
         spv1 <= spv;
         s2 <= s1;
         x2 <= x1;
         p2 <= PW'(ma1) * PW'(mb1);
         sp2 <= sp1;
         spv2 <= spv1;
      end
   end
`ifdef FP_MUL_FLAGS_EN
   always_ff @(posedge clk) begin
      if (adv) begin
         inv1 <= is_inv;
         inv2 <= inv1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) out_flags <= '0;
      else if (adv && v2) out_flags <= {inv2, !sp2 && ovf, !sp2 && unf, !sp2 && (ovf || unf || g || st)};
   end
`endif
endmodule
